// File: rtl/conv_acc_host_seq.sv
`default_nettype none
// ============================================================================
// Module   : conv_acc_host_seq
// Desc     : Host-side batch sequencer for the convolution accelerator.
//            Issues one start pulse per image, waits for the result strobe,
//            buffers each class result in a show-ahead FIFO and flags a
//            timeout when the accelerator does not answer.
//            Optional macro HOST_SCORE_EN adds label compare and score count.
// Revision : 1.0 - initial release
// ============================================================================
module conv_acc_host_seq #(
    parameter int RES_W      = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16,
    parameter int TIMEOUT    = 4096
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_run,
    input  logic [CNT_W-1:0] i_num_img,
    input  logic             i_clr,
    output logic             o_acc_start,
    input  logic [RES_W-1:0] i_acc_res,
    input  logic             i_acc_res_vld,
    input  logic             i_rd_en,
    output logic [RES_W-1:0] o_rd_data,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
`ifdef HOST_SCORE_EN
    input  logic [RES_W-1:0] i_label,
    output logic [CNT_W-1:0] o_score,
`endif
    output logic [CNT_W-1:0] o_img_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT) + 1;
    // The timer counts WAIT cycles starting at 0 in the first WAIT cycle, so
    // the last WAIT cycle (the one whose increment reaches TIMEOUT-1) holds
    // TIMEOUT-2; ERR is then entered exactly TIMEOUT cycles after START.
    localparam logic [TW-1:0] TIMER_LAST    = TW'(TIMEOUT - 2);
    localparam logic [AW:0]   FIFO_FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_STORE = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   num_q;
    logic [CNT_W-1:0]   img_cnt_q;
    logic [TW-1:0]      timer_q;
    logic [RES_W-1:0]   res_q;
    logic [AW-1:0]      wr_ptr_q;
    logic [AW-1:0]      rd_ptr_q;
    logic [AW:0]        cnt_q;
    logic [RES_W-1:0]   mem_q [FIFO_DEPTH];

    logic               w_batch_start;
    logic               w_push;
    logic               w_pop;
    logic [CNT_W-1:0]   w_img_cnt_inc;

    assign w_batch_start = (state_q == ST_IDLE) && i_run;
    // A full FIFO still accepts the write when the reader pops in the same cycle.
    assign w_push        = (state_q == ST_STORE) && (!o_full || i_rd_en);
    assign w_pop         = i_rd_en && !o_empty;
    assign w_img_cnt_inc = img_cnt_q + CNT_W'(1);

    assign o_empty   = (cnt_q == '0);
    assign o_full    = (cnt_q == FIFO_FULL_CNT);
    assign o_rd_data = o_empty ? '0 : mem_q[rd_ptr_q];
    assign o_img_cnt = img_cnt_q;

    // State register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        state_d     = state_q;
        o_acc_start = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        o_err       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_run) begin
                    state_d = (i_num_img == '0) ? ST_DONE : ST_START;
                end
            end
            ST_START: begin
                o_acc_start = 1'b1;
                o_busy      = 1'b1;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                o_busy = 1'b1;
                // A strobe coinciding with the last timer cycle still wins.
                if (i_acc_res_vld) begin
                    state_d = ST_STORE;
                end else if (timer_q == TIMER_LAST) begin
                    state_d = ST_ERR;
                end
            end
            ST_STORE: begin
                o_busy = 1'b1;
                if (w_push) begin
                    state_d = (w_img_cnt_inc == num_q) ? ST_DONE : ST_START;
                end
            end
            ST_DONE: begin
                o_done = 1'b1;
                if (i_clr) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERR: begin
                o_err = 1'b1;
                if (i_clr) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Batch bookkeeping: batch size, stored-image count, wait timer, captured result.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            num_q     <= '0;
            img_cnt_q <= '0;
            timer_q   <= '0;
            res_q     <= '0;
        end else begin
            if (w_batch_start) begin
                num_q     <= i_num_img;
                img_cnt_q <= '0;
            end
            if (state_q == ST_START) begin
                timer_q <= '0;
            end
            if (state_q == ST_WAIT) begin
                timer_q <= timer_q + TW'(1);
                if (i_acc_res_vld) begin
                    res_q <= i_acc_res;
                end
            end
            if (w_push) begin
                img_cnt_q <= w_img_cnt_inc;
            end
        end
    end

    // FIFO storage; contents need no reset since o_rd_data is masked while empty.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= res_q;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   cnt_q <= cnt_q + (AW + 1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW + 1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

`ifdef HOST_SCORE_EN
    logic             match_q;
    logic [CNT_W-1:0] score_q;

    assign o_score = score_q;

    // Label match is captured with the result and credited when that result is written.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            match_q <= 1'b0;
            score_q <= '0;
        end else begin
            if (w_batch_start) begin
                score_q <= '0;
            end
            if ((state_q == ST_WAIT) && i_acc_res_vld) begin
                match_q <= (i_acc_res == i_label);
            end
            if (w_push && match_q) begin
                score_q <= score_q + CNT_W'(1);
            end
        end
    end
`endif

endmodule
`default_nettype wire
